// File: rtl/fpu_classify_pipe_pkg.sv
// Shared FPU classification types: fclass bit positions, compare-op encodings,
// the pipeline entry record and the invalid-operation rule.
package fpu_classify_pipe_pkg;

  localparam logic [4:0] FCLASS_NEG_INF  = 5'd0;
  localparam logic [4:0] FCLASS_NEG_NORM = 5'd1;
  localparam logic [4:0] FCLASS_NEG_SUB  = 5'd2;
  localparam logic [4:0] FCLASS_NEG_ZERO = 5'd3;
  localparam logic [4:0] FCLASS_POS_ZERO = 5'd4;
  localparam logic [4:0] FCLASS_POS_SUB  = 5'd5;
  localparam logic [4:0] FCLASS_POS_NORM = 5'd6;
  localparam logic [4:0] FCLASS_POS_INF  = 5'd7;
  localparam logic [4:0] FCLASS_SNAN     = 5'd8;
  localparam logic [4:0] FCLASS_QNAN     = 5'd9;

  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

  typedef enum logic [2:0] {
    OP_LE = 3'b000,
    OP_LT = 3'b001,
    OP_EQ = 3'b010
  } cmp_op_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] class_a;
    logic [31:0] class_b;
    logic [2:0]  op;
    logic        nv;
    logic        illegal;
  } entry_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_LE) || (op == OP_LT) || (op == OP_EQ);
  endfunction

  // Ordered compares signal on any NaN; equality only on signalling NaNs.
  function automatic logic entry_nv(input logic [2:0]  op,
                                    input logic [31:0] class_a,
                                    input logic [31:0] class_b);
    logic any_snan;
    logic any_nan;
    any_snan = class_a[FCLASS_SNAN] | class_b[FCLASS_SNAN];
    any_nan  = any_snan | class_a[FCLASS_QNAN] | class_b[FCLASS_QNAN];
    if ((op == OP_LE) || (op == OP_LT)) begin
      return any_nan;
    end else if (op == OP_EQ) begin
      return any_snan;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/fpu_fclass.sv
// Combinational single-precision classifier producing a one-hot fclass code.
module fpu_fclass
  import fpu_classify_pipe_pkg::*;
(
  input  logic [31:0] operand_i,
  output logic [31:0] class_o
);

  logic        sign;
  logic [7:0]  expo;
  logic [22:0] mant;

  assign sign = operand_i[31];
  assign expo = operand_i[30:23];
  assign mant = operand_i[22:0];

  always_comb begin
    class_o = '0;
    if (expo == EXP_ALL_ONES) begin
      // NaN sign is deliberately ignored.
      if (mant == '0) begin
        class_o[sign ? FCLASS_NEG_INF : FCLASS_POS_INF] = 1'b1;
      end else if (mant[22]) begin
        class_o[FCLASS_QNAN] = 1'b1;
      end else begin
        class_o[FCLASS_SNAN] = 1'b1;
      end
    end else if (expo == '0) begin
      if (mant == '0) begin
        class_o[sign ? FCLASS_NEG_ZERO : FCLASS_POS_ZERO] = 1'b1;
      end else begin
        class_o[sign ? FCLASS_NEG_SUB : FCLASS_POS_SUB] = 1'b1;
      end
    end else begin
      class_o[sign ? FCLASS_NEG_NORM : FCLASS_POS_NORM] = 1'b1;
    end
  end

endmodule

// File: rtl/fpu_classify_pipe.sv
// Classifies an operand pair, flags invalid compares and passes the result
// through a 2-entry skid buffer with a registered in_ready.
module fpu_classify_pipe
  import fpu_classify_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [2:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [31:0] out_class_a,
  output logic [31:0] out_class_b,
  output logic [2:0]  out_op,
  output logic        out_nv,
  output logic        out_illegal,
  output logic        nv_sticky,
  input  logic        nv_clear
);

  logic [31:0] class_a;
  logic [31:0] class_b;
  entry_t      in_entry;

  entry_t out_q,       out_d;
  entry_t skid_q,      skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_full_q, skid_full_d;
  logic   in_ready_q,  in_ready_d;
  logic   nv_sticky_q, nv_sticky_d;

  logic accept;
  logic consume;

  fpu_fclass u_fclass_a (
    .operand_i (in_a),
    .class_o   (class_a)
  );

  fpu_fclass u_fclass_b (
    .operand_i (in_b),
    .class_o   (class_b)
  );

  always_comb begin
    in_entry         = '0;
    in_entry.a       = in_a;
    in_entry.b       = in_b;
    in_entry.class_a = class_a;
    in_entry.class_b = class_b;
    in_entry.op      = in_op;
    in_entry.illegal = !op_is_legal(in_op);
    in_entry.nv      = entry_nv(in_op, class_a, class_b);
  end

  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid_q & out_ready;

  always_comb begin
    out_d       = out_q;
    skid_d      = skid_q;
    out_valid_d = out_valid_q;
    skid_full_d = skid_full_q;

    // in_ready is low whenever the skid is full, so the refill branch never
    // coincides with an accepted entry.
    if (consume && skid_full_q) begin
      out_d       = skid_q;
      skid_full_d = 1'b0;
    end else if (accept) begin
      if (!out_valid_q || consume) begin
        out_d       = in_entry;
        out_valid_d = 1'b1;
      end else begin
        skid_d      = in_entry;
        skid_full_d = 1'b1;
      end
    end else if (consume) begin
      out_valid_d = 1'b0;
    end

    in_ready_d = !skid_full_d;

    // A setting handshake takes priority over a clear in the same cycle.
    if (consume && out_q.nv) begin
      nv_sticky_d = 1'b1;
    end else if (nv_clear) begin
      nv_sticky_d = 1'b0;
    end else begin
      nv_sticky_d = nv_sticky_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
      in_ready_q  <= 1'b0;
      nv_sticky_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      skid_full_q <= skid_full_d;
      in_ready_q  <= in_ready_d;
      nv_sticky_q <= nv_sticky_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_a       = out_q.a;
  assign out_b       = out_q.b;
  assign out_class_a = out_q.class_a;
  assign out_class_b = out_q.class_b;
  assign out_op      = out_q.op;
  assign out_nv      = out_q.nv;
  assign out_illegal = out_q.illegal;
  assign nv_sticky   = nv_sticky_q;

endmodule

// File: tb/tb_fpu_classify_pipe.sv
// Directed bench for fpu_classify_pipe: classification vectors, NV flag and
// sticky behaviour, skid backpressure ordering and mid-stream reset.
module tb_fpu_classify_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [31:0] out_class_a;
  logic [31:0] out_class_b;
  logic [2:0]  out_op;
  logic        out_nv;
  logic        out_illegal;
  logic        nv_sticky;
  logic        nv_clear;

  int n_assert = 0;
  int n_fail   = 0;

  fpu_classify_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_op       (in_op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_class_a (out_class_a),
    .out_class_b (out_class_b),
    .out_op      (out_op),
    .out_nv      (out_nv),
    .out_illegal (out_illegal),
    .nv_sticky   (nv_sticky),
    .nv_clear    (nv_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] ca;
    logic [31:0] cb;
    logic        nv;
    logic        illegal;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  vec_t vecs[11];
  logic exp_sticky;
  int   sent;
  int   recv;
  logic [31:0] exp_a;

  initial begin
    vecs[0]  = '{32'h7F800000, 32'h80000000, 3'b001, 32'h080, 32'h008, 1'b0, 1'b0};
    vecs[1]  = '{32'h7FA00000, 32'h3F800000, 3'b010, 32'h100, 32'h040, 1'b1, 1'b0};
    vecs[2]  = '{32'h7FC00000, 32'h3F800000, 3'b010, 32'h200, 32'h040, 1'b0, 1'b0};
    vecs[3]  = '{32'h7FC00000, 32'h3F800000, 3'b000, 32'h200, 32'h040, 1'b1, 1'b0};
    vecs[4]  = '{32'h3F800000, 32'h00000001, 3'b000, 32'h040, 32'h020, 1'b0, 1'b0};
    vecs[5]  = '{32'hBF800000, 32'h80800000, 3'b001, 32'h002, 32'h002, 1'b0, 1'b0};
    vecs[6]  = '{32'h7FC00000, 32'h00000000, 3'b011, 32'h200, 32'h010, 1'b0, 1'b1};
    vecs[7]  = '{32'hFF800000, 32'h807FFFFF, 3'b001, 32'h001, 32'h004, 1'b0, 1'b0};
    vecs[8]  = '{32'hFFC00000, 32'hFF800001, 3'b010, 32'h200, 32'h100, 1'b1, 1'b0};
    vecs[9]  = '{32'h00000000, 32'h7F7FFFFF, 3'b111, 32'h010, 32'h040, 1'b0, 1'b1};
    vecs[10] = '{32'h00000000, 32'h80000000, 3'b001, 32'h010, 32'h008, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    out_ready = 1'b1;
    nv_clear  = 1'b0;
    exp_sticky = 1'b0;

    #2;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready",  {31'd0, in_ready},  32'd0);
    chk("reset_sticky",    {31'd0, nv_sticky}, 32'd0);
    chk("reset_out_a",     out_a, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Table-driven classification with one entry in flight at a time.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = vecs[i].a;
      in_b     = vecs[i].b;
      in_op    = vecs[i].op;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i),   {31'd0, out_valid},   32'd1);
      chk($sformatf("v%0d_a", i),       out_a,                vecs[i].a);
      chk($sformatf("v%0d_b", i),       out_b,                vecs[i].b);
      chk($sformatf("v%0d_class_a", i), out_class_a,          vecs[i].ca);
      chk($sformatf("v%0d_class_b", i), out_class_b,          vecs[i].cb);
      chk($sformatf("v%0d_op", i),      {29'd0, out_op},      {29'd0, vecs[i].op});
      chk($sformatf("v%0d_nv", i),      {31'd0, out_nv},      {31'd0, vecs[i].nv});
      chk($sformatf("v%0d_illegal", i), {31'd0, out_illegal}, {31'd0, vecs[i].illegal});
      @(posedge clk); #1;
      exp_sticky = exp_sticky | vecs[i].nv;
      chk($sformatf("v%0d_drained", i), {31'd0, out_valid}, 32'd0);
      chk($sformatf("v%0d_sticky", i),  {31'd0, nv_sticky}, {31'd0, exp_sticky});
    end

    // Plain clear.
    @(negedge clk);
    nv_clear = 1'b1;
    @(posedge clk); #1;
    nv_clear = 1'b0;
    chk("sticky_cleared", {31'd0, nv_sticky}, 32'd0);

    // Clear coinciding with a setting handshake: set wins.
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 32'h7FA00000;
    in_b     = 32'h00000000;
    in_op    = 3'b010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("setwins_nv", {31'd0, out_nv}, 32'd1);
    nv_clear = 1'b1;
    @(posedge clk); #1;
    nv_clear = 1'b0;
    chk("setwins_sticky", {31'd0, nv_sticky}, 32'd1);

    // Continuous stream 1,2,3 with out_ready low for three cycles.
    sent = 0;
    recv = 0;
    in_b  = 32'h0;
    in_op = 3'b000;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      in_valid  = (sent < 3);
      in_a      = 32'(sent + 1);
      out_ready = (cyc >= 3);
      if (cyc == 2) begin
        chk("stall_accepted_two", 32'(sent), 32'd2);
        chk("stall_in_ready_low", {31'd0, in_ready}, 32'd0);
      end
      if (out_valid && !out_ready) begin
        chk($sformatf("stall_hold_c%0d", cyc), out_a, 32'd1);
      end
      if (out_valid && out_ready) begin
        exp_a = 32'(recv + 1);
        chk($sformatf("stream_order_%0d", recv), out_a, exp_a);
        recv++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    chk("stream_recv_count", 32'(recv), 32'd3);
    chk("stream_empty", {31'd0, out_valid}, 32'd0);

    // Fill both entries, then reset mid-stream.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 32'h7FA00000;
    in_op     = 3'b000;
    @(negedge clk);
    in_a      = 32'h7FA00000;
    @(negedge clk);
    in_valid  = 1'b0;
    chk("full_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("full_out_valid",    {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_in_ready",  {31'd0, in_ready},  32'd0);
    chk("midreset_sticky",    {31'd0, nv_sticky}, 32'd0);
    chk("midreset_out_a",     out_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready",  {31'd0, in_ready},  32'd1);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("no_reappear_%0d", k), {31'd0, out_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
